// File: rtl/fp_pkg.sv
// Shared FPU definitions: rounding-mode encodings, fp32 field widths,
// canonical quiet NaN, a leading-zero counter and the int-to-float FSM states.
package fp_pkg;

    localparam int FP_EXP_W    = 8;
    localparam int FP_MANT_W   = 23;
    localparam int FP_EXP_BIAS = 127;

    localparam logic [31:0] FP_QNAN = 32'h7fc00000;

    // Rounding-mode encodings
    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Biased exponent of an integer whose MSB sits at bit 31 (127 + 31)
    localparam logic [FP_EXP_W-1:0] I2F_EXP_INIT = 8'(FP_EXP_BIAS + 31);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } i2f_state_t;

    // Number of zero bits above the most significant one; 32 for a zero word.
    function automatic logic [5:0] leading_zero_count(input logic [31:0] value);
        logic [5:0] count;
        logic       found;
        count = 6'd32;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && value[i]) begin
                count = 6'(31 - i);
                found = 1'b1;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/fp_round_unit.sv
// Combinational fp32 mantissa rounding: decides the round increment from the
// guard/sticky bits and the rounding mode, and reports mantissa carry-out.
// Unknown rounding modes fall back to round-to-nearest-even and are flagged.
module fp_round_unit
    import fp_pkg::*;
(
    input  logic                 sign,
    input  logic [FP_MANT_W-1:0] mant,
    input  logic                 g,
    input  logic                 s,
    input  logic [2:0]           r_mode,
    output logic [FP_MANT_W-1:0] mant_out,
    output logic                 carry_out,
    output logic                 inexact,
    output logic                 invalid_rmode
);

    logic round_inc;

    // Round-increment decision per rounding mode
    always_comb begin
        round_inc     = 1'b0;
        invalid_rmode = 1'b0;
        case (r_mode)
            RM_RNE:  round_inc = g & (s | mant[0]);
            RM_RTZ:  round_inc = 1'b0;
            RM_RDN:  round_inc = sign & (g | s);
            RM_RUP:  round_inc = ~sign & (g | s);
            RM_RMM:  round_inc = g;
            default: begin
                round_inc     = g & (s | mant[0]);
                invalid_rmode = 1'b1;
            end
        endcase
    end

    // An all-ones mantissa plus one carries out into the exponent
    assign {carry_out, mant_out} = {1'b0, mant} + {{FP_MANT_W{1'b0}}, round_inc};
    assign inexact = g | s;

endmodule

// File: rtl/fp_int_to_float.sv
// 32-bit signed/unsigned integer to fp32 converter with valid/ready handshakes.
// Normalization is one bit per cycle by default; defining FP_I2F_FAST_NORM_EN
// normalizes with a single full-width shift in the first NORM cycle instead.
// Results and flags are identical in both builds.
module fp_int_to_float
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_int,
    input  logic        in_signed,
    input  logic [2:0]  r_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] fp_result,
    output logic        inexact,
    output logic        invalid_rmode
);

    i2f_state_t          state_reg, state_next;
    logic [31:0]         mag_reg, mag_next;
    logic [FP_EXP_W-1:0] exp_reg, exp_next;
    logic                sign_reg, sign_next;
    logic [2:0]          rm_reg, rm_next;
    logic [31:0]         result_reg, result_next;
    logic                inexact_reg, inexact_next;
    logic                invalid_reg, invalid_next;

    logic [31:0]          norm_mag;
    logic [FP_EXP_W-1:0]  norm_exp;
    logic [FP_MANT_W-1:0] rnd_mant;
    logic                 rnd_carry;
    logic                 rnd_inexact;
    logic                 rnd_invalid;
    logic                 in_sign;
    logic [31:0]          in_mag;

`ifdef FP_I2F_FAST_NORM_EN
    logic [5:0] lz_count;

    // Full normalization in one step: shift out every leading zero at once
    always_comb begin
        lz_count = leading_zero_count(mag_reg);
        norm_mag = mag_reg << lz_count;
        norm_exp = exp_reg - {2'b00, lz_count};
    end
`else
    // Serial normalization: the registered magnitude is rounded once its MSB is set
    assign norm_mag = mag_reg;
    assign norm_exp = exp_reg;
`endif

    // Operand sign and magnitude; -2^31 negates to 0x80000000 as required
    assign in_sign = in_signed & in_int[31];
    assign in_mag  = in_sign ? (~in_int + 32'd1) : in_int;

    fp_round_unit u_round (
        .sign          (sign_reg),
        .mant          (norm_mag[30:8]),
        .g             (norm_mag[7]),
        .s             (|norm_mag[6:0]),
        .r_mode        (rm_reg),
        .mant_out      (rnd_mant),
        .carry_out     (rnd_carry),
        .inexact       (rnd_inexact),
        .invalid_rmode (rnd_invalid)
    );

    // Next-state and datapath update for the accept / normalize / present sequence
    always_comb begin
        state_next   = state_reg;
        mag_next     = mag_reg;
        exp_next     = exp_reg;
        sign_next    = sign_reg;
        rm_next      = rm_reg;
        result_next  = result_reg;
        inexact_next = inexact_reg;
        invalid_next = invalid_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_next = in_sign;
                    mag_next  = in_mag;
                    exp_next  = I2F_EXP_INIT;
                    rm_next   = r_mode;
                    if (in_mag == 32'd0) begin
                        // Zero bypasses normalization and is always +0
                        result_next  = 32'h00000000;
                        inexact_next = 1'b0;
                        invalid_next = (r_mode > RM_RMM);
                        state_next   = ST_DONE;
                    end else begin
                        state_next = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (norm_mag[31]) begin
                    // Hidden bit in place: round and pack in this same cycle
                    result_next  = {sign_reg, norm_exp + {7'd0, rnd_carry}, rnd_mant};
                    inexact_next = rnd_inexact;
                    invalid_next = rnd_invalid;
                    state_next   = ST_DONE;
                end else begin
                    mag_next = {mag_reg[30:0], 1'b0};
                    exp_next = exp_reg - 8'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            mag_reg     <= 32'd0;
            exp_reg     <= '0;
            sign_reg    <= 1'b0;
            rm_reg      <= RM_RNE;
            result_reg  <= 32'd0;
            inexact_reg <= 1'b0;
            invalid_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mag_reg     <= mag_next;
            exp_reg     <= exp_next;
            sign_reg    <= sign_next;
            rm_reg      <= rm_next;
            result_reg  <= result_next;
            inexact_reg <= inexact_next;
            invalid_reg <= invalid_next;
        end
    end

    assign in_ready      = (state_reg == ST_IDLE) && rst_n;
    assign out_valid     = (state_reg == ST_DONE);
    assign fp_result     = result_reg;
    assign inexact       = inexact_reg;
    assign invalid_rmode = invalid_reg;

endmodule

// File: tb/tb_fp_int_to_float.sv
// Scoreboard bench for fp_int_to_float: a driver pushes expected results from
// an arithmetic reference model, a monitor pops and compares on each handshake.
module tb_fp_int_to_float;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_int = 32'd0;
    logic        in_signed = 1'b0;
    logic [2:0]  r_mode = 3'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] fp_result;
    logic        inexact;
    logic        invalid_rmode;

    fp_int_to_float dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_int        (in_int),
        .in_signed     (in_signed),
        .r_mode        (r_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fp_result     (fp_result),
        .inexact       (inexact),
        .invalid_rmode (invalid_rmode)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] res;
        logic        inx;
        logic        inv;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_pushed = 0;
    int   n_popped = 0;
    logic rand_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: value = m; find MSB position, round the dropped remainder
    // against half an ulp, renormalize on overflow to 2^24.
    function automatic exp_t model(input logic [31:0] v, input logic sg, input logic [2:0] rm);
        exp_t e;
        longint unsigned m, q, rem, half;
        int p, ex;
        logic neg, inc, any;
        neg = sg && v[31];
        m = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
        e.inv = (rm > 3'd4);
        e.acc = 0;
        if (m == 0) begin
            e.res = 32'd0;
            e.inx = 1'b0;
            e.lat = 1;
            return e;
        end
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        ex = 127 + p;
        if (p <= 23) begin
            q = m << (23 - p);
            rem = 0;
            half = 1;
        end else begin
            q = m >> (p - 23);
            rem = m - (q << (p - 23));
            half = 64'd1 << (p - 24);
        end
        any = (rem != 0);
        case (rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = neg && any;
            3'd3:    inc = !neg && any;
            3'd4:    inc = (rem >= half);
            default: inc = (rem > half) || ((rem == half) && q[0]);
        endcase
        q = q + {63'd0, inc};
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            ex++;
        end
        e.res = {neg, 8'(ex), q[22:0]};
        e.inx = any;
`ifdef FP_I2F_FAST_NORM_EN
        e.lat = 2;
`else
        e.lat = (31 - p) + 2;
`endif
        return e;
    endfunction

    // Drive one operand, hold it until accepted, record the expectation.
    task automatic send(input logic [31:0] v, input logic sg, input logic [2:0] rm,
                        input logic use_k, input logic [31:0] kres, input logic kinx);
        exp_t e;
        int   n;
        e = model(v, sg, rm);
        if (use_k) begin
            e.res = kres;
            e.inx = kinx;
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_int = v;
        in_signed = sg;
        r_mode = rm;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) begin
                e.acc = cycle + 1;
                sb.push_back(e);
                n_pushed++;
                break;
            end
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got in_ready=0, expected 1 within 500 cycles");
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_int = $urandom;
    endtask

    // Monitor: compare every consumed result and watch hold stability.
    initial begin
        exp_t e;
        logic        seen;
        int          first;
        logic [31:0] held;
        seen = 1'b0;
        first = 0;
        held = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    first = cycle;
                    held = fp_result;
                end else begin
                    chk("hold_stable", fp_result, held);
                end
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        n_popped++;
                        chk("fp_result", fp_result, e.res);
                        chk("inexact", {31'd0, inexact}, {31'd0, e.inx});
                        chk("invalid_rmode", {31'd0, invalid_rmode}, {31'd0, e.inv});
                        chk("latency", 32'(first - e.acc + 1), 32'(e.lat));
                        $display("txn %0d: result=%h inexact=%b invalid=%b latency=%0d",
                                 n_popped, fp_result, inexact, invalid_rmode, first - e.acc + 1);
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_fp_result", fp_result, 32'd0);
        chk("reset_inexact", {31'd0, inexact}, 32'd0);
        chk("reset_invalid", {31'd0, invalid_rmode}, 32'd0);

        // Directed vectors with hand-derived results
        send(32'h00000001, 1'b0, 3'd0, 1'b1, 32'h3F800000, 1'b0);
        send(32'h80000000, 1'b1, 3'd0, 1'b1, 32'hCF000000, 1'b0);
        send(32'h01000001, 1'b0, 3'd0, 1'b1, 32'h4B800000, 1'b1);
        send(32'h01000001, 1'b0, 3'd3, 1'b1, 32'h4B800001, 1'b1);
        send(32'h01000001, 1'b0, 3'd4, 1'b1, 32'h4B800001, 1'b1);
        send(32'h01000001, 1'b0, 3'd1, 1'b1, 32'h4B800000, 1'b1);
        send(32'hFFFFFFFF, 1'b0, 3'd0, 1'b1, 32'h4F800000, 1'b1);
        send(32'hFFFFFFFF, 1'b0, 3'd1, 1'b1, 32'h4F7FFFFF, 1'b1);
        send(32'hFFFFFFFF, 1'b1, 3'd2, 1'b1, 32'hBF800000, 1'b0);
        send(32'h00000000, 1'b1, 3'd5, 1'b1, 32'h00000000, 1'b0);

        // Backpressure: result held, a new operand is not taken
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'h00ABCDEF, 1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_int = 32'h00000055;
        in_signed = 1'b0;
        r_mode = 3'd0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(32'h00000055, 1'b0, 3'd0, 1'b0, 32'd0, 1'b0);

        // Reset in the middle of normalization drops the operand
        send(32'h00000001, 1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        n_pushed = n_pushed - sb.size();
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
        send(32'h12345678, 1'b1, 3'd0, 1'b0, 32'd0, 1'b0);

        // Random operands with random consumer stalls
        fork
            begin
                logic [31:0] v;
                for (int i = 0; i < 150; i++) begin
                    v = $urandom >> $urandom_range(0, 31);
                    if ($urandom_range(0, 15) == 0) v = 32'd0;
                    send(v, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0, 32'd0, 1'b0);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        chk("result_count", 32'(n_popped), 32'(n_pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
